// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - burst AXI responder backed by a byte-writable SRAM array
// Optional first-beat read latency: define AXI_SRAM_RD_DELAY_EN.
module axi_sram_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                RD_DELAY  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   io_axi_in_araddr,
  input  logic [7:0]          io_axi_in_arlen,
  input  logic                io_axi_in_arvalid,
  input  logic                io_axi_in_rready,
  input  logic [ADDR_W-1:0]   io_axi_in_awaddr,
  input  logic [7:0]          io_axi_in_awlen,
  input  logic                io_axi_in_awvalid,
  input  logic [DATA_W-1:0]   io_axi_in_wdata,
  input  logic [DATA_W/8-1:0] io_axi_in_wstrb,
  input  logic                io_axi_in_wvalid,
  input  logic                io_axi_in_bready,
  output logic                io_axi_out_arready,
  output logic                io_axi_out_awready,
  output logic [DATA_W-1:0]   io_axi_out_rdata,
  output logic                io_axi_out_rlast,
  output logic                io_axi_out_rvalid,
  output logic                io_axi_out_wready,
  output logic                io_axi_out_bvalid
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
`ifdef AXI_SRAM_RD_DELAY_EN
    RD_WAIT,
`endif
    RD_ADDR,
    RD,
    WR,
    BRESP
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] ar_off, aw_off;
  logic [IDX_W-1:0]  ar_idx, aw_idx;
  logic              last_beat;
  logic              unused_addr_bits;

  // DEPTH is a power of two, so dropping the upper offset bits is the modulo wrap
  assign ar_off    = io_axi_in_araddr - BASE_ADDR;
  assign aw_off    = io_axi_in_awaddr - BASE_ADDR;
  assign ar_idx    = ar_off[IDX_W+2:3];
  assign aw_idx    = aw_off[IDX_W+2:3];
  assign last_beat = (cnt_q == len_q);
  assign unused_addr_bits = ^{ar_off[2:0], ar_off[ADDR_W-1:IDX_W+3],
                              aw_off[2:0], aw_off[ADDR_W-1:IDX_W+3]};

`ifdef AXI_SRAM_RD_DELAY_EN
  logic [7:0] wait_q;
  logic       wait_done;

  assign wait_done = (wait_q == 8'(RD_DELAY - 1));

  always_ff @(posedge clock) begin
    if (reset || state_q != RD_WAIT) wait_q <= '0;
    else                             wait_q <= wait_q + 8'd1;
  end
`else
  logic unused_rd_delay;
  assign unused_rd_delay = ^RD_DELAY;
`endif

  always_comb begin
    state_d            = state_q;
    io_axi_out_arready = 1'b0;
    io_axi_out_awready = 1'b0;
    io_axi_out_rvalid  = 1'b0;
    io_axi_out_rlast   = 1'b0;
    io_axi_out_wready  = 1'b0;
    io_axi_out_bvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        io_axi_out_arready = io_axi_in_arvalid && !reset;
        io_axi_out_awready = io_axi_in_awvalid && !io_axi_in_arvalid && !reset;
        if (io_axi_in_arvalid) begin
`ifdef AXI_SRAM_RD_DELAY_EN
          state_d = RD_WAIT;
`else
          state_d = RD_ADDR;
`endif
        end else if (io_axi_in_awvalid) begin
          state_d = WR;
        end
      end
`ifdef AXI_SRAM_RD_DELAY_EN
      RD_WAIT: if (wait_done) state_d = RD_ADDR;
`endif
      RD_ADDR: state_d = RD;
      RD: begin
        io_axi_out_rvalid = 1'b1;
        io_axi_out_rlast  = last_beat;
        if (io_axi_in_rready) state_d = last_beat ? IDLE : RD_ADDR;
      end
      WR: begin
        io_axi_out_wready = 1'b1;
        if (io_axi_in_wvalid && last_beat) state_d = BRESP;
      end
      BRESP: begin
        io_axi_out_bvalid = 1'b1;
        if (io_axi_in_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (io_axi_in_arvalid) begin
            idx_q <= ar_idx;
            len_q <= io_axi_in_arlen;
          end else if (io_axi_in_awvalid) begin
            idx_q <= aw_idx;
            len_q <= io_axi_in_awlen;
          end
        end
        RD_ADDR: rdata_q <= mem[idx_q];
        RD: begin
          if (io_axi_in_rready && !last_beat) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        WR: begin
          if (io_axi_in_wvalid) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Array contents survive reset; a beat coinciding with reset is dropped
  always_ff @(posedge clock) begin
    if (!reset && state_q == WR && io_axi_in_wvalid) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (io_axi_in_wstrb[b]) mem[idx_q][8*b +: 8] <= io_axi_in_wdata[8*b +: 8];
      end
    end
  end

  assign io_axi_out_rdata = rdata_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - directed self-checking bench for axi_sram_responder
module tb_axi_sram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen, wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [63:0] wdata;
  logic        arready, awready, rlast, rvalid, wready, bvalid;
  logic [63:0] rdata;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int rd_lat = 0;

  logic [63:0] wbuf   [8];
  logic [63:0] rbuf   [8];
  logic [63:0] exp_rd [8];
  logic        lastbuf[8];

  axi_sram_responder dut (
    .clock              (clock),
    .reset              (reset),
    .io_axi_in_araddr   (araddr),
    .io_axi_in_arlen    (arlen),
    .io_axi_in_arvalid  (arvalid),
    .io_axi_in_rready   (rready),
    .io_axi_in_awaddr   (awaddr),
    .io_axi_in_awlen    (awlen),
    .io_axi_in_awvalid  (awvalid),
    .io_axi_in_wdata    (wdata),
    .io_axi_in_wstrb    (wstrb),
    .io_axi_in_wvalid   (wvalid),
    .io_axi_in_bready   (bready),
    .io_axi_out_arready (arready),
    .io_axi_out_awready (awready),
    .io_axi_out_rdata   (rdata),
    .io_axi_out_rlast   (rlast),
    .io_axi_out_rvalid  (rvalid),
    .io_axi_out_wready  (wready),
    .io_axi_out_bvalid  (bvalid)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_bit({tag, "_arready"}, arready, 1'b0);
    check_bit({tag, "_awready"}, awready, 1'b0);
    check_bit({tag, "_rvalid"},  rvalid,  1'b0);
    check_bit({tag, "_rlast"},   rlast,   1'b0);
    check    ({tag, "_rdata"},   rdata,   64'd0);
    check_bit({tag, "_wready"},  wready,  1'b0);
    check_bit({tag, "_bvalid"},  bvalid,  1'b0);
  endtask

  task automatic do_write(input logic [31:0] addr, input int n, input logic [7:0] strb);
    int g;
    awaddr = addr; awlen = 8'(n - 1); awvalid = 1'b1;
    #1;
    g = 0;
    while (!awready && g < 100) begin cyc(); #1; g++; end
    check_bit("wr_awready", awready, 1'b1);
    cyc();
    awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      wdata = wbuf[i]; wstrb = strb; wvalid = 1'b1;
      #1;
      check_bit("wr_wready", wready, 1'b1);
      cyc();
    end
    wvalid = 1'b0; bready = 1'b1;
    #1;
    check_bit("wr_bvalid", bvalid, 1'b1);
    cyc();
    bready = 1'b0;
    #1;
    check_bit("wr_bvalid_pulse", bvalid, 1'b0);
    cyc();
  endtask

  task automatic do_read(input logic [31:0] addr, input int n, input int stall_beat, input int stall_cycles);
    int g;
    araddr = addr; arlen = 8'(n - 1); arvalid = 1'b1; rready = 1'b1;
    #1;
    g = 0;
    while (!arready && g < 100) begin cyc(); #1; g++; end
    check_bit("rd_arready", arready, 1'b1);
    cyc();
    arvalid = 1'b0;
    rd_lat  = 1;
    #1;
    g = 0;
    while (!rvalid && g < 100) begin cyc(); #1; rd_lat++; g++; end
    for (int i = 0; i < n; i++) begin
      g = 0;
      while (!rvalid && g < 100) begin cyc(); #1; g++; end
      if (i == stall_beat) begin
        rready = 1'b0;
        for (int k = 0; k < stall_cycles; k++) begin
          cyc(); #1;
          check_bit("stall_rvalid", rvalid, 1'b1);
          check("stall_rdata", rdata, exp_rd[i]);
        end
        rready = 1'b1;
      end
      rbuf[i]    = rdata;
      lastbuf[i] = rlast;
      cyc(); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    cyc(); cyc(); cyc();
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    cyc();

    // single-beat write then read back
    wbuf[0] = 64'h1122_3344_5566_7788;
    do_write(32'h8000_0010, 1, 8'hFF);
    do_read(32'h8000_0010, 1, -1, 0);
    check("wr_rd_data", rbuf[0], 64'h1122_3344_5566_7788);
    check_bit("wr_rd_rlast", lastbuf[0], 1'b1);
    check("wr_rd_latency", 64'(rd_lat), 64'd2);

    // partial strobe merges into existing word
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'h8000_0000, 1, 8'hFF);
    wbuf[0] = 64'h0;
    do_write(32'h8000_0000, 1, 8'h0F);
    do_read(32'h8000_0000, 1, -1, 0);
    check("strobe_merge", rbuf[0], 64'hFFFF_FFFF_0000_0000);

    // 4-beat burst
    wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3; wbuf[3] = 64'd4;
    do_write(32'h8000_0100, 4, 8'hFF);
    do_read(32'h8000_0100, 4, -1, 0);
    check("burst_latency", 64'(rd_lat), 64'd2);
    check("burst_b0", rbuf[0], 64'd1);
    check("burst_b1", rbuf[1], 64'd2);
    check("burst_b2", rbuf[2], 64'd3);
    check("burst_b3", rbuf[3], 64'd4);
    check_bit("burst_last0", lastbuf[0], 1'b0);
    check_bit("burst_last1", lastbuf[1], 1'b0);
    check_bit("burst_last2", lastbuf[2], 1'b0);
    check_bit("burst_last3", lastbuf[3], 1'b1);

    // backpressure on beat 2 of the same burst
    exp_rd[0] = 64'd1; exp_rd[1] = 64'd2; exp_rd[2] = 64'd3; exp_rd[3] = 64'd4;
    do_read(32'h8000_0100, 4, 1, 5);
    check("bp_b0", rbuf[0], 64'd1);
    check("bp_b1", rbuf[1], 64'd2);
    check("bp_b2", rbuf[2], 64'd3);
    check("bp_b3", rbuf[3], 64'd4);
    check_bit("bp_last3", lastbuf[3], 1'b1);

    // simultaneous read and write requests: read first
    wbuf[0] = 64'hA5A5_5A5A_0F0F_F0F0;
    araddr = 32'h8000_0100; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h8000_0200; awlen = 8'd0; awvalid = 1'b1;
    #1;
    check_bit("both_arready", arready, 1'b1);
    check_bit("both_awready", awready, 1'b0);
    cyc();
    arvalid = 1'b0;
    #1;
    check_bit("busy_awready", awready, 1'b0);
    cyc(); #1;
    check_bit("both_rvalid", rvalid, 1'b1);
    check("both_rdata", rdata, 64'd1);
    check_bit("both_rlast", rlast, 1'b1);
    cyc(); #1;
    check_bit("deferred_awready", awready, 1'b1);
    cyc();
    awvalid = 1'b0; wdata = wbuf[0]; wstrb = 8'hFF; wvalid = 1'b1;
    #1;
    check_bit("deferred_wready", wready, 1'b1);
    cyc();
    wvalid = 1'b0; bready = 1'b1;
    #1;
    check_bit("deferred_bvalid", bvalid, 1'b1);
    cyc();
    bready = 1'b0;
    do_read(32'h8000_0200, 1, -1, 0);
    check("deferred_data", rbuf[0], 64'hA5A5_5A5A_0F0F_F0F0);

    // index wrap from DEPTH-1 to 0 on writes and reads; aliasing above the array
    wbuf[0] = 64'hAAAA_0000_0000_0FFF;
    wbuf[1] = 64'hBBBB_0000_0000_0000;
    do_write(32'h8000_7FF8, 2, 8'hFF);
    do_read(32'h8000_7FF8, 2, -1, 0);
    check("wrap_b0", rbuf[0], 64'hAAAA_0000_0000_0FFF);
    check("wrap_b1", rbuf[1], 64'hBBBB_0000_0000_0000);
    check_bit("wrap_last1", lastbuf[1], 1'b1);
    do_read(32'h8000_8004, 1, -1, 0);
    check("alias_word0", rbuf[0], 64'hBBBB_0000_0000_0000);

    // reset during beat 1 of a 4-beat write
    awaddr = 32'h8000_0300; awlen = 8'd3; awvalid = 1'b1;
    #1;
    check_bit("rst_awready", awready, 1'b1);
    cyc();
    awvalid = 1'b0; wdata = 64'h1111_2222_3333_4444; wstrb = 8'hFF; wvalid = 1'b1;
    cyc();
    wdata = 64'h5555_6666_7777_8888;
    reset = 1'b1;
    cyc();
    reset = 1'b0; wvalid = 1'b0;
    #1;
    check_idle_outputs("midreset");
    cyc();
    do_read(32'h8000_0300, 1, -1, 0);
    check("midreset_beat0", rbuf[0], 64'h1111_2222_3333_4444);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
